// File: rtl/eth_phy_10g_rx_link_mon_pkg.sv
// rtl/eth_phy_10g_rx_link_mon_pkg.sv - shared constants and helpers for the 10GBASE-R RX link monitor
package eth_phy_10g_rx_link_mon_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Counter preload for an N-cycle interval; a zero-length interval still lasts one cycle.
    function automatic int floor_dec(input int n);
        return (n > 0) ? n - 1 : 0;
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_link_mon_if.sv
// rtl/eth_phy_10g_rx_link_mon_if.sv - SERDES/decoder-side signal bundle for the RX link monitor
interface eth_phy_10g_rx_link_mon_if #(
    parameter int HDR_W = 2
);
    logic [HDR_W-1:0] serdes_rx_hdr;
    logic             serdes_rx_hdr_valid;
    logic             rx_bad_block;
    logic             rx_sequence_error;
    logic             serdes_rx_bitslip;
    logic             serdes_rx_reset_req;
    logic             rx_block_lock;
    logic             rx_high_ber;
    logic             rx_status;

    modport master (
        output serdes_rx_hdr, serdes_rx_hdr_valid, rx_bad_block, rx_sequence_error,
        input  serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock, rx_high_ber, rx_status
    );

    modport slave (
        input  serdes_rx_hdr, serdes_rx_hdr_valid, rx_bad_block, rx_sequence_error,
        output serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock, rx_high_ber, rx_status
    );
endinterface

// File: rtl/taxi_eth_phy_10g_rx_ber_mon.sv
// rtl/taxi_eth_phy_10g_rx_ber_mon.sv - high bit-error-rate detection over fixed 125 us windows
module taxi_eth_phy_10g_rx_ber_mon
    import eth_phy_10g_rx_link_mon_pkg::*;
#(
    parameter int HDR_W       = 2,
    parameter int COUNT_125US = 19531
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [HDR_W-1:0] hdr_i,
    input  logic             hdr_valid_i,
    output logic             high_ber_o
);
    localparam int TIME_W = $clog2(COUNT_125US + 1);

    logic [TIME_W-1:0] time_count_q, time_count_d;
    logic [3:0]        ber_count_q, ber_count_d;
    logic              high_ber_q, high_ber_d;
    logic              hdr_ok;

    assign hdr_ok = (hdr_i == SYNC_DATA) || (hdr_i == SYNC_CTRL);

    always_comb begin
        time_count_d = time_count_q;
        ber_count_d  = ber_count_q;
        high_ber_d   = high_ber_q;
        if (time_count_q != '0) time_count_d = time_count_q - TIME_W'(1);
        if (hdr_valid_i) begin
            if (hdr_ok) begin
                if (ber_count_q != 4'd15 && time_count_q == '0) high_ber_d = 1'b0;
            end else if (ber_count_q == 4'd15) begin
                high_ber_d = 1'b1;
            end else begin
                ber_count_d = ber_count_q + 4'd1;
                if (time_count_q == '0) high_ber_d = 1'b0;
            end
        end
        // Window rollover wins over any error counted in the same cycle.
        if (time_count_q == '0) begin
            ber_count_d  = '0;
            time_count_d = TIME_W'(COUNT_125US);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_count_q <= TIME_W'(COUNT_125US);
            ber_count_q  <= '0;
            high_ber_q   <= 1'b0;
        end else begin
            time_count_q <= time_count_d;
            ber_count_q  <= ber_count_d;
            high_ber_q   <= high_ber_d;
        end
    end

    assign high_ber_o = high_ber_q;
endmodule

// File: rtl/taxi_eth_phy_10g_rx_frame_sync.sv
// rtl/taxi_eth_phy_10g_rx_frame_sync.sv - 64b/66b block lock acquisition with bitslip control
module taxi_eth_phy_10g_rx_frame_sync
    import eth_phy_10g_rx_link_mon_pkg::*;
#(
    parameter int HDR_W               = 2,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [HDR_W-1:0] hdr_i,
    input  logic             hdr_valid_i,
    output logic             bitslip_o,
    output logic             block_lock_o
);
    localparam int SLIP_HI = floor_dec(BITSLIP_HIGH_CYCLES);
    localparam int SLIP_LO = floor_dec(BITSLIP_LOW_CYCLES);
    localparam int SLIP_W  = $clog2(((SLIP_HI > SLIP_LO) ? SLIP_HI : SLIP_LO) + 2);

    logic [5:0]        sh_count_q, sh_count_d;
    logic [3:0]        sh_invalid_count_q, sh_invalid_count_d;
    logic [SLIP_W-1:0] bitslip_count_q, bitslip_count_d;
    logic              bitslip_q, bitslip_d;
    logic              lock_q, lock_d;
    logic              hdr_ok;

    assign hdr_ok = (hdr_i == SYNC_DATA) || (hdr_i == SYNC_CTRL);

    always_comb begin
        sh_count_d         = sh_count_q;
        sh_invalid_count_d = sh_invalid_count_q;
        bitslip_count_d    = bitslip_count_q;
        bitslip_d          = bitslip_q;
        lock_d             = lock_q;
        // While a slip is in progress the SERDES output is unsettled, so headers are not counted.
        if (bitslip_count_q != '0) begin
            bitslip_count_d = bitslip_count_q - SLIP_W'(1);
        end else if (bitslip_q) begin
            bitslip_d       = 1'b0;
            bitslip_count_d = SLIP_W'(SLIP_LO);
        end else if (hdr_valid_i) begin
            sh_count_d = sh_count_q + 6'd1;
            if (hdr_ok) begin
                if (sh_count_q == 6'd63) begin
                    sh_count_d         = '0;
                    sh_invalid_count_d = '0;
                    if (sh_invalid_count_q == '0) lock_d = 1'b1;
                end
            end else begin
                sh_invalid_count_d = sh_invalid_count_q + 4'd1;
                if (!lock_q || sh_invalid_count_q == 4'd15) begin
                    sh_count_d         = '0;
                    sh_invalid_count_d = '0;
                    lock_d             = 1'b0;
                    bitslip_d          = 1'b1;
                    bitslip_count_d    = SLIP_W'(SLIP_HI);
                end else if (sh_count_q == 6'd63) begin
                    sh_count_d         = '0;
                    sh_invalid_count_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_count_q         <= '0;
            sh_invalid_count_q <= '0;
            bitslip_count_q    <= '0;
            bitslip_q          <= 1'b0;
            lock_q             <= 1'b0;
        end else begin
            sh_count_q         <= sh_count_d;
            sh_invalid_count_q <= sh_invalid_count_d;
            bitslip_count_q    <= bitslip_count_d;
            bitslip_q          <= bitslip_d;
            lock_q             <= lock_d;
        end
    end

    assign bitslip_o    = bitslip_q;
    assign block_lock_o = lock_q;
endmodule

// File: rtl/taxi_eth_phy_10g_rx_watchdog.sv
// rtl/taxi_eth_phy_10g_rx_watchdog.sv - link status qualification and SERDES RX reset request
module taxi_eth_phy_10g_rx_watchdog
    import eth_phy_10g_rx_link_mon_pkg::*;
#(
    parameter int HDR_W       = 2,
    parameter int COUNT_125US = 19531
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [HDR_W-1:0] hdr_i,
    input  logic             hdr_valid_i,
    input  logic             bad_block_i,
    input  logic             sequence_error_i,
    input  logic             block_lock_i,
    input  logic             high_ber_i,
    output logic             reset_req_o,
    output logic             status_o
);
    localparam int TIME_W = $clog2(COUNT_125US + 1);

    logic [TIME_W-1:0] time_count_q, time_count_d;
    logic [3:0]        error_count_q, error_count_d;
    logic [3:0]        status_count_q, status_count_d;
    logic [9:0]        block_err_count_q, block_err_count_d;
    logic              saw_ctrl_q, saw_ctrl_d;
    logic              status_q, status_d;
    logic              reset_req_q, reset_req_d;
    logic              unused_high_ber;

    assign unused_high_ber = high_ber_i;

    always_comb begin
        time_count_d      = time_count_q;
        error_count_d     = error_count_q;
        status_count_d    = status_count_q;
        block_err_count_d = block_err_count_q;
        saw_ctrl_d        = saw_ctrl_q;
        status_d          = status_q;
        reset_req_d       = 1'b0;
        if (block_lock_i) begin
            if (hdr_valid_i && hdr_i == SYNC_CTRL) saw_ctrl_d = 1'b1;
            if ((bad_block_i || sequence_error_i) && block_err_count_q != 10'd1023)
                block_err_count_d = block_err_count_q + 10'd1;
        end else begin
            status_d       = 1'b0;
            status_count_d = '0;
        end
        if (time_count_q != '0) begin
            time_count_d = time_count_q - TIME_W'(1);
        end else begin
            time_count_d = TIME_W'(COUNT_125US);
            // A window is good only if control blocks were seen and the error count did not saturate.
            if (!saw_ctrl_q || block_err_count_q == 10'd1023) begin
                error_count_d  = error_count_q + 4'd1;
                status_count_d = '0;
            end else begin
                error_count_d = '0;
                if (status_count_q != 4'd15) status_count_d = status_count_q + 4'd1;
            end
            if (error_count_q == 4'd15) begin
                error_count_d = '0;
                reset_req_d   = 1'b1;
            end
            if (status_count_q == 4'd15 && block_lock_i) status_d = 1'b1;
            saw_ctrl_d        = 1'b0;
            block_err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_count_q      <= TIME_W'(COUNT_125US);
            error_count_q     <= '0;
            status_count_q    <= '0;
            block_err_count_q <= '0;
            saw_ctrl_q        <= 1'b0;
            status_q          <= 1'b0;
            reset_req_q       <= 1'b0;
        end else begin
            time_count_q      <= time_count_d;
            error_count_q     <= error_count_d;
            status_count_q    <= status_count_d;
            block_err_count_q <= block_err_count_d;
            saw_ctrl_q        <= saw_ctrl_d;
            status_q          <= status_d;
            reset_req_q       <= reset_req_d;
        end
    end

    assign reset_req_o = reset_req_q;
    assign status_o    = status_q;
endmodule

// File: rtl/eth_phy_10g_rx_link_mon.sv
// rtl/eth_phy_10g_rx_link_mon.sv - 10GBASE-R RX link monitor: frame sync, BER monitor and watchdog
module eth_phy_10g_rx_link_mon
    import eth_phy_10g_rx_link_mon_pkg::*;
#(
    parameter int HDR_W               = 2,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 7,
    parameter int COUNT_125US         = $rtoi(125000 / 6.4)
) (
    input  logic                          clk,
    input  logic                          rst,
    eth_phy_10g_rx_link_mon_if.slave      rx
);
    if (HDR_W != 2) begin : g_hdr_w_check
        $fatal(1, "HDR_W must be 2");
    end

    logic block_lock;
    logic high_ber;

    taxi_eth_phy_10g_rx_frame_sync #(
        .HDR_W               (HDR_W),
        .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
        .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES)
    ) u_frame_sync (
        .clk          (clk),
        .rst          (rst),
        .hdr_i        (rx.serdes_rx_hdr),
        .hdr_valid_i  (rx.serdes_rx_hdr_valid),
        .bitslip_o    (rx.serdes_rx_bitslip),
        .block_lock_o (block_lock)
    );

    taxi_eth_phy_10g_rx_ber_mon #(
        .HDR_W       (HDR_W),
        .COUNT_125US (COUNT_125US)
    ) u_ber_mon (
        .clk         (clk),
        .rst         (rst),
        .hdr_i       (rx.serdes_rx_hdr),
        .hdr_valid_i (rx.serdes_rx_hdr_valid),
        .high_ber_o  (high_ber)
    );

    taxi_eth_phy_10g_rx_watchdog #(
        .HDR_W       (HDR_W),
        .COUNT_125US (COUNT_125US)
    ) u_watchdog (
        .clk              (clk),
        .rst              (rst),
        .hdr_i            (rx.serdes_rx_hdr),
        .hdr_valid_i      (rx.serdes_rx_hdr_valid),
        .bad_block_i      (rx.rx_bad_block),
        .sequence_error_i (rx.rx_sequence_error),
        .block_lock_i     (block_lock),
        .high_ber_i       (high_ber),
        .reset_req_o      (rx.serdes_rx_reset_req),
        .status_o         (rx.rx_status)
    );

    assign rx.rx_block_lock = block_lock;
    assign rx.rx_high_ber   = high_ber;
endmodule

// File: tb/tb_eth_phy_10g_rx_link_mon.sv
// tb/tb_eth_phy_10g_rx_link_mon.sv - directed self-checking bench for the RX link monitor
module tb_eth_phy_10g_rx_link_mon;
    localparam logic [1:0] HD = 2'b01;
    localparam logic [1:0] HC = 2'b10;

    typedef struct {
        logic [1:0] hdr;
        logic       valid;
        logic       bs;
        logic       lk;
        logic       hb;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    eth_phy_10g_rx_link_mon_if #(.HDR_W(2)) bus ();

    eth_phy_10g_rx_link_mon #(
        .HDR_W               (2),
        .BITSLIP_HIGH_CYCLES (1),
        .BITSLIP_LOW_CYCLES  (7),
        .COUNT_125US         (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0b expected %0b", name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_bitslip"}, 0, bus.serdes_rx_bitslip, 1'b0);
        check({name, "_reset_req"}, 0, bus.serdes_rx_reset_req, 1'b0);
        check({name, "_lock"}, 0, bus.rx_block_lock, 1'b0);
        check({name, "_high_ber"}, 0, bus.rx_high_ber, 1'b0);
        check({name, "_status"}, 0, bus.rx_status, 1'b0);
    endtask

    task automatic add(input int n, input logic [1:0] h, input logic bs, input logic lk, input logic hb);
        vec_t e;
        e.hdr = h; e.valid = 1'b1; e.bs = bs; e.lk = lk; e.hb = hb;
        repeat (n) tbl.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.serdes_rx_hdr       = HD;
        bus.serdes_rx_hdr_valid = 1'b0;
        bus.rx_bad_block        = 1'b0;
        bus.rx_sequence_error   = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;

        // Row r is applied before edge r after reset; expectations are the outputs after that edge.
        add(63, HD,    1'b0, 1'b0, 1'b0);
        add(1,  HD,    1'b0, 1'b1, 1'b0);
        add(15, 2'b00, 1'b0, 1'b1, 1'b0);
        add(49, HD,    1'b0, 1'b1, 1'b0);
        add(15, 2'b11, 1'b0, 1'b1, 1'b0);
        add(1,  2'b11, 1'b1, 1'b0, 1'b1);
        add(7,  2'b00, 1'b0, 1'b0, 1'b1);
        add(1,  2'b00, 1'b1, 1'b0, 1'b1);
        add(70, HD,    1'b0, 1'b0, 1'b1);
        add(80, HD,    1'b0, 1'b1, 1'b1);
        add(1,  HD,    1'b0, 1'b1, 1'b0);

        do_reset();
        check_all_zero("reset");

        for (int r = 0; r < tbl.size(); r++) begin
            bus.serdes_rx_hdr       = tbl[r].hdr;
            bus.serdes_rx_hdr_valid = tbl[r].valid;
            tick();
            check("bitslip", r, bus.serdes_rx_bitslip, tbl[r].bs);
            check("lock", r, bus.rx_block_lock, tbl[r].lk);
            check("high_ber", r, bus.rx_high_ber, tbl[r].hb);
            check("reset_req", r, bus.serdes_rx_reset_req, 1'b0);
            check("status", r, bus.rx_status, 1'b0);
        end

        // Good windows: CTRL headers after lock, status rises on the 16th timer expiry.
        do_reset();
        pulses = 0;
        for (int k = 0; k < 1620; k++) begin
            bus.serdes_rx_hdr       = (k < 64) ? HD : HC;
            bus.serdes_rx_hdr_valid = 1'b1;
            tick();
            if (bus.serdes_rx_reset_req) pulses++;
            if (k == 62)   check("good_lock_pre", k, bus.rx_block_lock, 1'b0);
            if (k == 63)   check("good_lock", k, bus.rx_block_lock, 1'b1);
            if (k == 1514) check("status_early", k, bus.rx_status, 1'b0);
            if (k == 1614) check("status_pre", k, bus.rx_status, 1'b0);
            if (k == 1615) check("status_rise", k, bus.rx_status, 1'b1);
            if (k == 1619) check("status_hold", k, bus.rx_status, 1'b1);
        end
        check_int("good_reset_req_pulses", pulses, 0);
        check("good_lock_end", 1619, bus.rx_block_lock, 1'b1);

        // Reset while locked with status up clears every output on the next edge.
        rst = 1'b1;
        tick();
        check_all_zero("mid_reset");

        // No CTRL headers: reset request pulses at the 16th and 32nd expiry only.
        do_reset();
        pulses = 0;
        for (int k = 0; k <= 3233; k++) begin
            bus.serdes_rx_hdr       = HD;
            bus.serdes_rx_hdr_valid = 1'b1;
            tick();
            if (bus.serdes_rx_reset_req) pulses++;
            if (k == 1614) check("rreq_pre1", k, bus.serdes_rx_reset_req, 1'b0);
            if (k == 1615) check("rreq_pulse1", k, bus.serdes_rx_reset_req, 1'b1);
            if (k == 1616) check("rreq_post1", k, bus.serdes_rx_reset_req, 1'b0);
            if (k == 3230) check("rreq_pre2", k, bus.serdes_rx_reset_req, 1'b0);
            if (k == 3231) check("rreq_pulse2", k, bus.serdes_rx_reset_req, 1'b1);
            if (k == 3232) check("rreq_post2", k, bus.serdes_rx_reset_req, 1'b0);
        end
        check_int("bad_reset_req_pulses", pulses, 2);
        check("bad_status", 3233, bus.rx_status, 1'b0);
        check("bad_lock", 3233, bus.rx_block_lock, 1'b1);
        check("bad_high_ber", 3233, bus.rx_high_ber, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eth_phy_10g_rx_link_mon.md
# eth_phy_10g_rx_link_mon

10GBASE-R receive-side link monitor for the 64b/66b PCS RX path. It sits after the SERDES pipeline and bit-reverse stage, and takes the 2-bit sync header per block. It does three things:
- Frame sync: acquires block lock and pulses bitslip to the SERDES.
- BER monitor: flags high bit-error rate over 125 µs windows.
- Watchdog: requests a SERDES RX reset and qualifies overall RX link status.

## Interface
Parameters:
- HDR_W, 2: sync header width; any other value is a fatal elaboration error.
- BITSLIP_HIGH_CYCLES, 1: cycles bitslip is held high per slip.
- BITSLIP_LOW_CYCLES, 7: cycles headers are ignored after bitslip drops.
- COUNT_125US, 125000/6.4: clock cycles per 125 µs, converted to an integer (default 19531). Counter width is $clog2(COUNT_125US+1).

Ports:
- clk, in, 1: the only clock.
- rst, in, 1: reset, synchronous, active-high.
- serdes_rx_hdr, in, HDR_W: sync header. 2'b01 = DATA, 2'b10 = CTRL, 00/11 = invalid.
- serdes_rx_hdr_valid, in, 1: qualifies serdes_rx_hdr.
- rx_bad_block, in, 1: decoder bad-block pulse.
- rx_sequence_error, in, 1: decoder sequence-error pulse.
- serdes_rx_bitslip, out, 1: slip request to the SERDES.
- serdes_rx_reset_req, out, 1: one-cycle SERDES RX reset request.
- rx_block_lock, out, 1: block lock acquired.
- rx_high_ber, out, 1: high BER detected.
- rx_status, out, 1: link status good.

## Operation
Frame sync state (all zero on reset):
- sh_count: 6 bits.
- sh_invalid_count: 4 bits.
- bitslip_count.
- bitslip register.
- lock register.

Frame sync, per cycle, first matching rule wins:
1. bitslip_count≠0: decrement it.
2. Else if bitslip is high: drop bitslip; load bitslip_count with BITSLIP_LOW_CYCLES−1 (0 if that parameter is 0).
3. Else if hdr_valid is low: hold all state.
4. Else if the header is valid (DATA or CTRL): increment sh_count. When sh_count==63, clear sh_count and sh_invalid_count; if sh_invalid_count==0, set lock.
5. Else (invalid header): increment sh_count and sh_invalid_count.
   - If lock is low, or sh_invalid_count==15: clear both counters, clear lock, raise bitslip, and load bitslip_count with BITSLIP_HIGH_CYCLES−1 (0 if that parameter is 0).
   - Otherwise, if sh_count==63: clear both counters.

BER monitor state:
- time_count: reset to COUNT_125US.
- ber_count: 4 bits, reset 0.
- high_ber: reset 0.

BER monitor, per cycle:
- time_count≠0: decrement it.
- hdr_valid with a valid header: if ber_count≠15 and time_count==0, clear high_ber.
- hdr_valid with an invalid header: if ber_count==15, set high_ber. Otherwise increment ber_count, and clear high_ber if time_count==0.
- time_count==0: ber_count←0 and time_count←COUNT_125US. This overrides the increment in the same cycle.

Watchdog state (reset values):
- time_count = COUNT_125US.
- error_count = 0 (4 bits).
- status_count = 0 (4 bits).
- saw_ctrl = 0.
- block_err_count = 0 (10 bits).
- status = 0; reset_req = 0.

Watchdog, while lock is high:
- hdr_valid with a CTRL header sets saw_ctrl.
- (bad_block | sequence_error) increments block_err_count, saturating at 1023.

Watchdog, while lock is low: status←0 and status_count←0.

Watchdog reset_req defaults to 0 every cycle. If time_count≠0, decrement it. Otherwise (time_count==0):
- Reload time_count with COUNT_125US.
- If !saw_ctrl or block_err_count==1023: increment error_count and clear status_count. Otherwise: clear error_count and increment status_count, saturating at 15.
- If error_count==15: error_count←0 and pulse reset_req.
- If status_count==15: status←1.
- Clear saw_ctrl and block_err_count.
- When the timer expires in the same cycle that lock is low, the timer's status_count assignments override the lock-loss clear. status is still cleared.

Outputs and rx_high_ber input:
- Outputs are the registers directly.
- rx_high_ber is routed to the watchdog but does not affect it.

## Timing
- All outputs are registered; a response appears on the clock edge after the causing input.
- The frame sync, BER monitor and watchdog 125 µs timers are independent.
- Reset mid-operation returns every register to its reset value on the next edge. All outputs are 0 after reset.
- Bitslip pulse width: max(BITSLIP_HIGH_CYCLES, 1) cycles. It is followed by max(BITSLIP_LOW_CYCLES, 1) cycles of low bitslip with headers ignored; headers are considered again on the cycle after.
- Lock is acquired after 64 consecutive valid headers counted from a window start with no invalid header in that window.
- Lock is lost on the 16th invalid header within a 64-header window.
- serdes_rx_reset_req is a 1-cycle pulse after 16 consecutive failing windows.
- rx_status rises after 16 consecutive good windows.

## Structure
- Shared package holds constants SYNC_DATA=2'b01 and SYNC_CTRL=2'b10.
- Three sub-modules: taxi_eth_phy_10g_rx_frame_sync, taxi_eth_phy_10g_rx_ber_mon, taxi_eth_phy_10g_rx_watchdog.
- The top level wires rx_block_lock and rx_high_ber internally into the watchdog.

## Test plan
Run with COUNT_125US=100.
1. Continuous DATA headers with hdr_valid=1 from reset: rx_block_lock rises after 64 headers; no bitslip.
2. Invalid header while unlocked: serdes_rx_bitslip high 1 cycle, then 7 cycles where headers are ignored.
3. Locked link with 15 invalid headers in a 64-header window: lock held. 16 invalid headers: lock drops and a bitslip pulse follows.
4. 16 invalid headers within one window: rx_high_ber=1. Next window with all valid headers, at timer expiry: rx_high_ber returns to 0.
5. Lock held with a CTRL header in every window: rx_status rises at the 16th expiry. No CTRL headers at all: serdes_rx_reset_req pulses once every 16 windows.
6. Assert rst mid-lock: all outputs are 0 on the next edge.
